// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register pending-writeback scoreboard for RAW hazard detection.
module riscv_regfile_mp #(
  parameter int XLEN          = 32,
  parameter int NUM_RD        = 4,
  parameter int NUM_WR        = 2,
  parameter bit BYPASS_EN     = 1'b1,
  parameter bit SCOREBOARD_EN = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_WR*5-1:0]    rd_i,
  input  logic [NUM_WR*XLEN-1:0] rd_value_i,
  input  logic [NUM_RD*5-1:0]    ra_i,
  output logic [NUM_RD*XLEN-1:0] ra_value_o,
  output logic [NUM_RD-1:0]      busy_o,
  input  logic [NUM_WR-1:0]      iss_valid_i,
  input  logic [NUM_WR*5-1:0]    iss_rd_i,
  input  logic                   flush_i,
  output logic [31:0]            busy_mask_o
);

  logic [XLEN-1:0] regs [1:31];
  logic [31:0]     sb;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the array is reset explicitly because software relies on zeroed registers,
  // which keeps this a flop array rather than a RAM macro.
  // Later ports are visited last, so the highest-numbered port wins a conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 1; r < 32; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        for (int r = 1; r < 32; r++) begin
          if (rd_i[5*k +: 5] == 5'(r)) regs[r] <= rd_value_i[XLEN*k +: XLEN];
        end
      end
    end
  end

  logic [4:0]      idx;
  logic [XLEN-1:0] rdata;
  logic            wr_hit;
  logic            iss_hit;

  // NOTE: every variable gets a default at the top of the block so no latch is inferred.
  always_comb begin
    ra_value_o = '0;
    busy_o     = '0;
    idx        = '0;
    rdata      = '0;
    wr_hit     = 1'b0;
    iss_hit    = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      idx     = ra_i[5*p +: 5];
      rdata   = '0;
      wr_hit  = 1'b0;
      iss_hit = 1'b0;
      for (int r = 1; r < 32; r++) begin
        if (idx == 5'(r)) rdata = regs[r];
      end
      for (int k = 0; k < NUM_WR; k++) begin
        if (idx != 5'd0 && rd_i[5*k +: 5] == idx) begin
          wr_hit = 1'b1;
          if (BYPASS_EN) rdata = rd_value_i[XLEN*k +: XLEN];
        end
        if (iss_valid_i[k] && iss_rd_i[5*k +: 5] == idx) iss_hit = 1'b1;
      end
      ra_value_o[XLEN*p +: XLEN] = rdata;
      // A completing writeback hides the stale busy bit unless a new producer re-arms it.
      busy_o[p] = sb[idx] && !(BYPASS_EN && wr_hit && !iss_hit);
    end
  end

  generate
    if (SCOREBOARD_EN) begin : g_sb
      logic [31:0] sb_next;

      // Clear, then set, then flush: a re-issue beats its own writeback.
      always_comb begin
        sb_next = sb;
        for (int k = 0; k < NUM_WR; k++) sb_next[rd_i[5*k +: 5]] = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
          if (iss_valid_i[k]) sb_next[iss_rd_i[5*k +: 5]] = 1'b1;
        end
        if (flush_i) sb_next = '0;
        sb_next[0] = 1'b0;
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) sb <= '0;
        else       sb <= sb_next;
      end
    end else begin : g_no_sb
      assign sb = '0;
    end
  endgenerate

  assign busy_mask_o = sb;

  // Debug accessor for simulation: stored value of register r, 0 for x0.
  function automatic logic [XLEN-1:0] get_register(input logic [4:0] r);
    get_register = '0;
    for (int i = 1; i < 32; i++) begin
      if (r == 5'(i)) get_register = regs[i];
    end
  endfunction

endmodule
